// File: rtl/pipelined_csa_multiplier_pkg.sv
// Sizing helpers for the carry-save reduction tree and the per-stage control word
// that travels alongside each operation.
package mult_pkg;

  typedef struct packed {
    logic valid;
    logic signed_f;
  } stage_ctl_t;

  function automatic int unsigned prod_w(input int unsigned width);
    return 32'd2 * width;
  endfunction

  // One 3:2 level turns every full triple into two rows; leftover rows pass through.
  function automatic int unsigned rows_after(input int unsigned rows);
    return 32'd2 * (rows / 32'd3) + (rows % 32'd3);
  endfunction

  function automatic int unsigned rows_at(input int unsigned rows0, input int unsigned level);
    int unsigned n;
    n = rows0;
    for (int unsigned i = 32'd0; i < level; i++) n = rows_after(n);
    return n;
  endfunction

  function automatic int unsigned csa_levels(input int unsigned rows0);
    int unsigned n;
    int unsigned lv;
    n  = rows0;
    lv = 32'd0;
    while (n > 32'd2) begin
      n  = rows_after(n);
      lv = lv + 32'd1;
    end
    return lv;
  endfunction

  function automatic int unsigned levels_per_stage(input int unsigned levels, input int unsigned stages);
    return levels / stages;
  endfunction

  // Earlier stages absorb the remainder, one extra level each.
  function automatic int unsigned first_level(input int unsigned levels, input int unsigned stages,
                                              input int unsigned stage);
    int unsigned rem;
    rem = levels % stages;
    return stage * levels_per_stage(levels, stages) + ((stage < rem) ? stage : rem);
  endfunction

endpackage

// File: rtl/pipelined_csa_multiplier_csa_row.sv
// One row of full adders: three vectors in, sum vector and left-shifted carry vector out.
module csa_row #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] z_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  assign sum_o   = x_i ^ y_i ^ z_i;
  // The carry out of the top bit falls off: the product is kept modulo 2^W.
  assign carry_o = {(x_i[W-2:0] & y_i[W-2:0]) | (x_i[W-2:0] & z_i[W-2:0]) | (y_i[W-2:0] & z_i[W-2:0]), 1'b0};

endmodule

// File: rtl/pipelined_csa_multiplier.sv
// WIDTH x WIDTH multiplier: AND/Baugh-Wooley partial products, 3:2 reduction spread over
// PIPE_STAGES-1 register stages, final carry-propagate add in the output stage.
module pipelined_csa_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PIPE_STAGES = 3,
  parameter bit          SIGNED_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product
);

  localparam int unsigned PW      = prod_w(WIDTH);
  localparam int unsigned NR      = WIDTH;
  localparam int unsigned NL      = csa_levels(WIDTH);
  localparam int unsigned NS      = PIPE_STAGES - 32'd1;
  localparam int unsigned MAX_LEV = levels_per_stage(NL, NS) + (((NL % NS) != 32'd0) ? 32'd1 : 32'd0);
  localparam int unsigned NSTEP   = (MAX_LEV > 32'd0) ? MAX_LEV : 32'd1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  // Baugh-Wooley correction ones at bit WIDTH and bit 2*WIDTH-1, added in the final adder.
  localparam logic [PW-1:0]    BW_CONST = (PW'(1'b1) << WIDTH) | (PW'(1'b1) << (PW - 32'd1));

  logic              op_signed;
  logic [PW-1:0]     pp [NR];
  logic [NS-1:0]     adv;
  logic [NS-1:0]     stage_vld;
  logic              out_adv;
  logic              out_valid_q;
  logic [PW-1:0]     out_product_q;
  logic [PW-1:0]     product_d;

  assign op_signed = SIGNED_EN & in_signed;
  assign out_adv   = ~out_valid_q | out_ready;
  assign in_ready  = adv[0];

  // Partial-product rows; in signed mode the cross terms touching exactly one MSB are inverted.
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      pp[i] = {{WIDTH{1'b0}},
               ({WIDTH{in_b[i]}} & in_a) ^
               (op_signed ? ((i == int'(WIDTH) - 1) ? ~MSB_MASK : MSB_MASK) : {WIDTH{1'b0}})} << i;
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_stage
    localparam int unsigned FIRST = first_level(NL, NS, s);
    localparam int unsigned NLEV  = first_level(NL, NS, s + 1) - FIRST;

    stage_ctl_t    ctl_d;
    stage_ctl_t    ctl_q;
    logic [PW-1:0] st_in  [NR];
    logic [PW-1:0] rows_q [NR];

    if (s == 0) begin : g_src
      assign st_in          = pp;
      assign ctl_d.valid    = in_valid;
      assign ctl_d.signed_f = in_valid & op_signed;
    end else begin : g_chain
      assign st_in = g_stage[s-1].rows_q;
      assign ctl_d = g_stage[s-1].ctl_q;
    end

    assign stage_vld[s] = ctl_q.valid;
    // A stage moves when any stage from here to the output is empty or the sink drains.
    assign adv[s] = out_adv | ~(&stage_vld[NS-1:s]);

    for (genvar k = 0; k < NSTEP; k++) begin : g_lvl
      logic [PW-1:0] cur [NR];
      logic [PW-1:0] nxt [NR];

      if (k == 0) begin : g_head
        assign cur = st_in;
      end else begin : g_link
        assign cur = g_lvl[k-1].nxt;
      end

      if (k < NLEV) begin : g_red
        localparam int unsigned NIN  = rows_at(NR, FIRST + k);
        localparam int unsigned NG   = NIN / 32'd3;
        localparam int unsigned NOUT = rows_after(NIN);

        for (genvar g = 0; g < NG; g++) begin : g_csa
          csa_row #(.W(PW)) u_row (
            .x_i     (cur[3*g]),
            .y_i     (cur[3*g+1]),
            .z_i     (cur[3*g+2]),
            .sum_o   (nxt[2*g]),
            .carry_o (nxt[2*g+1])
          );
        end
        for (genvar r = 3 * NG; r < NIN; r++) begin : g_pass
          assign nxt[r-NG] = cur[r];
        end
        for (genvar r = NOUT; r < NR; r++) begin : g_zero
          assign nxt[r] = '0;
        end
      end else begin : g_idle
        assign nxt = cur;
      end
    end

    // Stage register: control always follows the handshake, data loads only for a live op.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q <= '0;
        for (int r = 0; r < int'(NR); r++) rows_q[r] <= '0;
      end else if (adv[s]) begin
        ctl_q <= ctl_d;
        if (ctl_d.valid) rows_q <= g_lvl[NSTEP-1].nxt;
      end
    end
  end

  // Final carry-propagate add; the carry out of the top bit is dropped.
  always_comb begin
    product_d = g_stage[NS-1].rows_q[0] + g_stage[NS-1].rows_q[1] +
                (g_stage[NS-1].ctl_q.signed_f ? BW_CONST : {PW{1'b0}});
  end

  // Output register holds its product while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else if (out_adv) begin
      out_valid_q <= g_stage[NS-1].ctl_q.valid;
      if (g_stage[NS-1].ctl_q.valid) out_product_q <= product_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;

endmodule

// File: tb/tb_pipelined_csa_multiplier.sv
// Scoreboard bench: the driver queues expected products on every accepted operand pair,
// a negedge monitor pops and compares whenever an output is consumed.
module tb_pipelined_csa_multiplier;

  localparam int unsigned W  = 8;
  localparam int unsigned P  = 3;
  localparam int unsigned PW = 2 * W;

  typedef struct {
    logic [PW-1:0] prod;
    int            acc;
    bit            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_signed;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_product;

  exp_t          sb_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            run_len = 0;
  int            max_run = 0;
  int            valid_cnt = 0;
  bit            hold = 1'b0;
  logic [PW-1:0] hold_val = '0;

  pipelined_csa_multiplier #(.WIDTH(W), .PIPE_STAGES(P), .SIGNED_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer multiplication of the operands read as signed or unsigned.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint x;
    longint y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return PW'(x * y);
  endfunction

  // Monitor: stall stability, valid-run bookkeeping and scoreboard pops.
  always @(negedge clk) begin
    exp_t e;
    if (hold) begin
      check("hold_valid", longint'(out_valid), 1);
      check("hold_data", longint'(out_product), longint'(hold_val));
    end
    hold     = out_valid && !out_ready;
    hold_val = out_product;
    if (out_valid) begin
      run_len++;
      valid_cnt++;
    end else begin
      run_len = 0;
    end
    if (run_len > max_run) max_run = run_len;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h expected no output (cycle %0d)", out_product, cyc);
      end else begin
        e = sb_q.pop_front();
        check("product", longint'(out_product), longint'(e.prod));
        if (e.lat) check("latency", longint'(cyc - e.acc), longint'(P));
      end
    end
  end

  // One driver cycle: present inputs, record the op if it is accepted, step past the edge.
  task automatic issue_cycle(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit s, input logic [PW-1:0] exp, input bit lat, output bit acc);
    exp_t e;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    acc       = 1'b0;
    @(negedge clk);
    if (v && in_ready) begin
      e.prod = exp;
      e.acc  = cyc;
      e.lat  = lat;
      sb_q.push_back(e);
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input logic [PW-1:0] exp);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) issue_cycle(1'b1, a, b, s, exp, 1'b1, acc);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && sb_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_left", longint'(sb_q.size()), 0);
  endtask

  initial begin
    bit            acc;
    int            n_acc;
    int            issued;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    bit            s;
    logic [PW-1:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_product", longint'(out_product), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Corner products with spec-given expectations.
    send(8'd255, 8'd255, 1'b0, 16'hFE01);
    send(8'd0,   8'd200, 1'b0, 16'h0000);
    send(8'd1,   8'd173, 1'b0, 16'h00AD);
    send(8'h80,  8'h80,  1'b1, 16'h4000);
    send(8'hFF,  8'h7F,  1'b1, 16'hFF81);
    send(8'hF8,  8'h07,  1'b1, 16'hFFC8);
    send(8'h80,  8'h80,  1'b0, 16'h4000);
    send(8'hFF,  8'h7F,  1'b0, 16'h7E81);
    send(8'hF8,  8'h07,  1'b0, 16'h06C8);
    drain();

    // Ten back-to-back operations at full throughput.
    max_run = 0;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_signed = s;
      @(negedge clk);
      check("b2b_in_ready", longint'(in_ready), 1);
      if (in_ready) sb_q.push_back('{ref_mul(a, b, s), cyc, 1'b1});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    check("b2b_valid_run", longint'(max_run), 10);

    // Backpressure: fill the pipe, hold the sink off, then release.
    out_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom);
      issue_cycle(1'b1, a, b, s, ref_mul(a, b, s), 1'b0, acc);
      n_acc += int'(acc);
    end
    in_valid = 1'b0;
    check("bp_accepted", longint'(n_acc), longint'(P));
    @(negedge clk);
    check("bp_in_ready", longint'(in_ready), 0);
    check("bp_out_valid", longint'(out_valid), 1);
    held = out_product;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_stable", longint'(out_product), longint'(held));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // A bubble between two ops collapses while the output stalls.
    out_ready = 1'b0;
    issue_cycle(1'b1, 8'd13, 8'd11, 1'b0, 16'd143, 1'b0, acc);
    issue_cycle(1'b0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0, acc);
    issue_cycle(1'b1, 8'hF0, 8'h03, 1'b1, 16'hFFD0, 1'b0, acc);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bubble_in_ready", longint'(in_ready), 1);
    check("bubble_out_valid", longint'(out_valid), 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset with ops in flight: outputs clear at once and nothing emerges later.
    for (int c = 0; c < 3; c++) begin
      a = W'($urandom);
      b = W'($urandom);
      issue_cycle(1'b1, a, b, 1'b0, ref_mul(a, b, 1'b0), 1'b0, acc);
    end
    in_valid = 1'b0;
    check("rst_pre_valid", longint'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", longint'(out_valid), 0);
    check("rst_async_product", longint'(out_product), 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    valid_cnt = 0;
    repeat (12) @(posedge clk);
    #1;
    check("rst_no_ghost", longint'(valid_cnt), 0);

    // Random traffic with random valid, ready and signedness.
    issued = 0;
    for (int c = 0; c < 20000 && issued < 2500; c++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      issue_cycle($urandom_range(0, 3) != 0, a, b, s, ref_mul(a, b, s), 1'b0, acc);
      issued += int'(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_issued", longint'(issued), 2500);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
